// File: rtl/alu_seq_muldiv_if.sv
// alu_seq_muldiv_if: operand/result handshake bundle between the ID/EX operand
// muxes (master) and the sequential execute-stage ALU (slave).
interface alu_seq_muldiv_if #(
  parameter int XLEN = 32
);
  // Request side: op + operands, valid/ready handshake.
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;

  // Response side: result + illegal qualifier, valid/ready handshake.
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: registered, handshaked execute-stage ALU.
//  - Base ops (codes 0..13) finish one cycle after accept.
//  - Configuration macro ALU_MULDIV_EN: when defined, RV32M ops (codes 16..23)
//    run on an iterative datapath: XLEN shift-add / restoring-divide steps
//    followed by one sign-fix cycle. When undefined, that datapath and the
//    CALC state are absent and codes 16..23 report illegal like any other
//    unsupported code.
//  - flush aborts whatever is in flight; result keeps its last delivered value.
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  alu_seq_muldiv_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [4:0] {
    OP_ZERO   = 5'd0,
    OP_ADD    = 5'd1,
    OP_SUB    = 5'd2,
    OP_SLL    = 5'd3,
    OP_SLT    = 5'd4,
    OP_SLTU   = 5'd5,
    OP_XOR    = 5'd6,
    OP_SRL    = 5'd7,
    OP_SRA    = 5'd8,
    OP_OR     = 5'd9,
    OP_AND    = 5'd10,
    OP_SLLI   = 5'd11,
    OP_SRLI   = 5'd12,
    OP_SRAI   = 5'd13,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } op_e;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_e;
`endif

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_ill;

  assign accept        = bus.in_valid && in_ready_q;
  assign shamt         = bus.b[SHW-1:0];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;

  // Single-cycle base ALU; anything it does not recognise is flagged illegal.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // assignment on some path would otherwise infer a latch.
    base_res = '0;
    base_ill = 1'b0;
    case (bus.op)
      OP_ZERO:          base_res = '0;
      OP_ADD:           base_res = bus.a + bus.b;
      OP_SUB:           base_res = bus.a - bus.b;
      OP_SLL, OP_SLLI:  base_res = bus.a << shamt;
      OP_SLT:           base_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU:          base_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      OP_XOR:           base_res = bus.a ^ bus.b;
      OP_SRL, OP_SRLI:  base_res = bus.a >> shamt;
      OP_SRA, OP_SRAI:  base_res = $signed(bus.a) >>> shamt;
      OP_OR:            base_res = bus.a | bus.b;
      OP_AND:           base_res = bus.a & bus.b;
      default:          base_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN);

  // Iteration state. hi/lo double as {partial product, multiplier} for
  // multiply and {partial remainder, dividend->quotient} for divide;
  // dvs holds the multiplicand or divisor magnitude.
  logic [XLEN:0]   md_hi_q;
  logic [XLEN-1:0] md_lo_q;
  logic [XLEN-1:0] md_dvs_q;
  logic [SHW:0]    md_cnt_q;
  logic            md_div_q;
  logic            md_hi_sel_q;
  logic            md_neg_q;

  logic            md_op;
  logic            is_div;
  logic            signed_a;
  logic            signed_b;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            res_neg;
  logic            cnt_last;

  logic [XLEN-1:0] mul_addend;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] md_sel;
  logic [XLEN-1:0] md_res;

  assign md_op    = (bus.op[4:3] == 2'b10);
  assign is_div   = bus.op[2];
  assign cnt_last = (md_cnt_q == CNT_LAST);

  // Operand sign handling at accept: iteration always runs on magnitudes.
  always_comb begin
    signed_a = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    signed_b = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    neg_a    = signed_a && bus.a[XLEN-1];
    neg_b    = signed_b && bus.b[XLEN-1];
    mag_a    = neg_a ? -bus.a : bus.a;
    mag_b    = neg_b ? -bus.b : bus.b;
    // Remainder follows the dividend; a zero-divisor quotient stays all ones.
    if (bus.op == OP_REM)
      res_neg = neg_a;
    else if (is_div)
      res_neg = (neg_a ^ neg_b) && (bus.b != '0);
    else
      res_neg = neg_a ^ neg_b;
  end

  // One radix-2 step of each algorithm; only the one matching md_div_q is used.
  always_comb begin
    mul_addend = md_lo_q[0] ? md_dvs_q : '0;
    mul_sum    = md_hi_q + {1'b0, mul_addend};
    div_shift  = {md_hi_q[XLEN-1:0], md_lo_q[XLEN-1]};
    div_trial  = div_shift - {1'b0, md_dvs_q};
  end

  // Final-cycle sign fix. The high word of a negated 2*XLEN product borrows
  // from the low word only when the low word is zero.
  always_comb begin
    md_sel = md_hi_sel_q ? md_hi_q[XLEN-1:0] : md_lo_q;
    md_res = md_sel;
    if (md_neg_q) begin
      if (md_hi_sel_q && !md_div_q)
        md_res = ~md_hi_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, (md_lo_q == '0)};
      else
        md_res = -md_sel;
    end
  end

  // Load magnitudes on accept, then step once per CALC cycle until the count ends.
  // NOTE: datapath registers carry no reset; they are always loaded at accept
  // before use, and only the reset FSM decides when their contents are seen.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && accept && md_op) begin
      md_hi_q     <= '0;
      md_lo_q     <= mag_a;
      md_dvs_q    <= mag_b;
      md_cnt_q    <= '0;
      md_div_q    <= is_div;
      md_hi_sel_q <= is_div ? bus.op[1] : (bus.op[1:0] != 2'b00);
      md_neg_q    <= res_neg;
    end else if (state_q == S_CALC && !cnt_last) begin
      md_cnt_q <= md_cnt_q + 1'b1;
      if (md_div_q) begin
        if (!div_trial[XLEN]) begin
          md_hi_q <= div_trial;
          md_lo_q <= {md_lo_q[XLEN-2:0], 1'b1};
        end else begin
          md_hi_q <= div_shift;
          md_lo_q <= {md_lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        md_hi_q <= {1'b0, mul_sum[XLEN:1]};
        md_lo_q <= {mul_sum[0], md_lo_q[XLEN-1:1]};
      end
    end
  end
`endif

  // Control FSM with registered handshake outputs; flush outranks everything
  // except reset.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            if (md_op) begin
              state_q <= S_CALC;
            end else
`endif
            begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= base_res;
              illegal_q   <= base_ill;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        S_CALC: begin
          if (cnt_last) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_res;
            illegal_q   <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: directed vectors for alu_seq_muldiv. Stimulus pushes the
// expected response into a scoreboard queue; an independent monitor pops and
// compares when out_valid rises and rechecks while the result is held.
// Multiply/divide vectors follow the ALU_MULDIV_EN build setting.
module tb_alu_seq_muldiv;

  localparam int XLEN  = 32;
  localparam int MDLAT = XLEN + 1;

  localparam logic [4:0] OP_ZERO   = 5'd0;
  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_SLL    = 5'd3;
  localparam logic [4:0] OP_SLT    = 5'd4;
  localparam logic [4:0] OP_SLTU   = 5'd5;
  localparam logic [4:0] OP_XOR    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_OR     = 5'd9;
  localparam logic [4:0] OP_AND    = 5'd10;
  localparam logic [4:0] OP_SLLI   = 5'd11;
  localparam logic [4:0] OP_SRLI   = 5'd12;
  localparam logic [4:0] OP_SRAI   = 5'd13;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_seq_muldiv_if #(.XLEN(XLEN)) bus ();

  alu_seq_muldiv #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    string           name;
    logic [XLEN-1:0] res;
    logic            ill;
    int              lat;   // edges after the accepting edge before out_valid is seen
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pop on the rising edge of out_valid, recheck every held cycle.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_ov  = 1'b0;

  always @(negedge clk) begin
    if (!rstn || !bus.out_valid) begin
      have_cur = 1'b0;
      prev_ov  = 1'b0;
    end else begin
      if (!prev_ov) begin
        check("sb_has_item", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check({cur.name, "_lat"}, 64'(cyc - acc_cyc), 64'(cur.lat));
        end
      end
      if (have_cur) begin
        check({cur.name, "_res"}, 64'(bus.result), 64'(cur.res));
        check({cur.name, "_ill"}, 64'(bus.illegal), 64'(cur.ill));
      end
      if (bus.out_ready) have_cur = 1'b0;
      prev_ov = 1'b1;
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic send(input string name, input logic [4:0] op,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] er, input logic ei,
                      input int lat, input bit push);
    exp_t e;
    wait_ready(name);
    #1;
    if (push) begin
      e.name = name;
      e.res  = er;
      e.ill  = ei;
      e.lat  = lat;
      sb.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(sb.size() != 0 || bus.out_valid), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_result"},    64'(bus.result),    64'd0);
    check({tag, "_illegal"},   64'(bus.illegal),   64'd0);
  endtask

  // Global bound so a stuck DUT can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d tests so far", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset values.
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rstn = 1'b1;

    // add 4+4 held for several cycles with out_ready low.
    bus.out_ready = 1'b0;
    send("add_hold", OP_ADD, 32'd4, 32'd4, 32'd8, 1'b0, 0, 1'b1);
    repeat (4) @(negedge clk);
    #1 bus.out_ready = 1'b1;
    drain("add_hold");

    // Base op vectors.
    send("sub",   OP_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE, 1'b0, 0, 1'b1);
    send("addw",  OP_ADD,  32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b0, 0, 1'b1);
    send("sll",   OP_SLL,  32'd1,          32'h0000_0021,  32'h0000_0002, 1'b0, 0, 1'b1);
    send("slli",  OP_SLLI, 32'h8000_0001,  32'h0000_001F,  32'h8000_0000, 1'b0, 0, 1'b1);
    send("slt",   OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,         1'b0, 0, 1'b1);
    send("sltu",  OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,         1'b0, 0, 1'b1);
    send("xor",   OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 1'b0, 0, 1'b1);
    send("or",    OP_OR,   32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0, 1'b0, 0, 1'b1);
    send("and",   OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 1'b0, 0, 1'b1);
    send("sra",   OP_SRA,  32'hFFFF_FFF0,  32'h0000_0022,  32'hFFFF_FFFC, 1'b0, 0, 1'b1);
    send("srl",   OP_SRL,  32'hFFFF_FFF0,  32'h0000_0022,  32'h3FFF_FFFC, 1'b0, 0, 1'b1);
    send("srai",  OP_SRAI, 32'h8000_0000,  32'h0000_003F,  32'hFFFF_FFFF, 1'b0, 0, 1'b1);
    send("srli",  OP_SRLI, 32'h8000_0000,  32'h0000_003F,  32'h0000_0001, 1'b0, 0, 1'b1);
    send("zero",  OP_ZERO, 32'd5,          32'd6,          32'd0,         1'b0, 0, 1'b1);
    send("ill31", 5'd31,   32'd5,          32'd6,          32'd0,         1'b1, 0, 1'b1);
    send("ill14", 5'd14,   32'd5,          32'd6,          32'd0,         1'b1, 0, 1'b1);
    send("ill24", 5'd24,   32'd5,          32'd6,          32'd0,         1'b1, 0, 1'b1);
    drain("base");

`ifdef ALU_MULDIV_EN
    // mulh with in_ready watched for the whole calculation.
    send("mulh", OP_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 1'b0, MDLAT, 1'b1);
    bad = 0;
    for (int i = 0; i < MDLAT; i++) begin
      @(negedge clk);
      if (bus.in_ready) bad++;
    end
    check("mulh_in_ready_busy", 64'(bad), 64'd0);
    drain("mulh");

    send("mul",     OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, MDLAT, 1'b1);
    send("mulhu",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MDLAT, 1'b1);
    send("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MDLAT, 1'b1);
    send("mulhsu2", OP_MULHSU, 32'd2,         32'h8000_0000, 32'h0000_0001, 1'b0, MDLAT, 1'b1);
    send("div0",    OP_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, MDLAT, 1'b1);
    send("rem0",    OP_REM,    32'd7,         32'd0,         32'd7,         1'b0, MDLAT, 1'b1);
    send("divn0",   OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, MDLAT, 1'b1);
    send("remn0",   OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, MDLAT, 1'b1);
    send("divovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, MDLAT, 1'b1);
    send("removf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, MDLAT, 1'b1);
    send("divneg",  OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, MDLAT, 1'b1);
    send("remneg",  OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, MDLAT, 1'b1);
    send("divu",    OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, MDLAT, 1'b1);
    send("remu",    OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0, MDLAT, 1'b1);
    send("divu1",   OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, MDLAT, 1'b1);
    drain("md");

    // Flush in the 10th CALC cycle of divu: no output, ready right after.
    send("divu_flush", OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, MDLAT, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_calc_in_ready", 64'(bus.in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      if (bus.out_valid) bad++;
      @(negedge clk);
    end
    check("flush_calc_no_valid", 64'(bad), 64'd0);
`else
    // Multiply/divide codes are unsupported in this build.
    send("ill16", OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'd0, 1'b1, 0, 1'b1);
    send("ill20", OP_DIV, 32'd7,         32'd0, 32'd0, 1'b1, 0, 1'b1);
    drain("md_ill");
`endif

    // Flush in DONE together with out_ready: the result is dropped.
    bus.out_ready = 1'b0;
    send("flush_done", OP_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 0, 1'b1);
    @(negedge clk);
    #1;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_done_in_ready",  64'(bus.in_ready),  64'd1);

    // Flush coincident with an accept: the op is not taken.
    wait_ready("flush_acc");
    #1;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 32'd2;
    bus.b        = 32'd3;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) bad++;
    end
    check("flush_acc_ignored", 64'(bad), 64'd0);

    send("add_after_flush", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b1);
    drain("after_flush");

    // Asynchronous reset pulse while an op is in flight.
`ifdef ALU_MULDIV_EN
    send("mul_rst", OP_MUL, 32'd9, 32'd9, 32'd0, 1'b0, MDLAT, 1'b0);
    repeat (5) @(negedge clk);
`else
    bus.out_ready = 1'b0;
    send("add_rst", OP_ADD, 32'd9, 32'd9, 32'd18, 1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);
`endif
    #1 rstn = 1'b0;
    #1;
    check_reset_values("rst_pulse");
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1 rstn = 1'b1;

    send("add_after_rst", OP_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 0, 1'b1);
    drain("end");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
